// File: rtl/stopwatch_mmss.sv
// Up-counting mm:ss stopwatch with start/stop, clear and lap-freeze; saturates at 59:59 and
// blinks. Generates its own 1 Hz tick from MCLK and drives four BCD digits.
module stopwatch_mmss #(
    parameter int unsigned CLK_HZ = 25175000
) (
    input  logic       MCLK,
    input  logic       RST_N,
    input  logic       START_STOP,
    input  logic       CLEAR,
    input  logic       LAP,
    output logic [2:0] MIN_1,
    output logic [3:0] MIN_0,
    output logic [2:0] SEC_1,
    output logic [3:0] SEC_0,
    output logic       RUNNING,
    output logic       LAP_ACTIVE,
    output logic       DONE,
    output logic       BLINK
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    // Count packed as {min_1[2:0], min_0[3:0], sec_1[2:0], sec_0[3:0]}.
    localparam logic [13:0] CNT_MAX = {3'd5, 4'd9, 3'd5, 4'd9};

    typedef enum logic [1:0] {StStop, StRun, StLap, StDone} state_e;

    state_e        state_q, state_d;
    logic [13:0]   cnt_q, cnt_d;
    logic [13:0]   latch_q, latch_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          blink_q, blink_d;
    logic          ss_q, clr_q, lap_btn_q;
    logic          running_q, lap_active_q, done_q;
    logic          ss_ev, clr_ev, lap_ev, tick, at_max;

    function automatic logic [13:0] incr(input logic [13:0] c);
        logic [2:0] m1;
        logic [3:0] m0;
        logic [2:0] s1;
        logic [3:0] s0;
        {m1, m0, s1, s0} = c;
        if (s0 == 4'd9) begin
            s0 = 4'd0;
            if (s1 == 3'd5) begin
                s1 = 3'd0;
                if (m0 == 4'd9) begin
                    m0 = 4'd0;
                    m1 = m1 + 3'd1;
                end else begin
                    m0 = m0 + 4'd1;
                end
            end else begin
                s1 = s1 + 3'd1;
            end
        end else begin
            s0 = s0 + 4'd1;
        end
        return {m1, m0, s1, s0};
    endfunction

    assign ss_ev  = ss_q & ~START_STOP;
    assign clr_ev = clr_q & ~CLEAR;
    assign lap_ev = lap_btn_q & ~LAP;
    assign tick   = (state_q != StStop) && (presc_q == PRESC_MAX);
    assign at_max = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        blink_d = 1'b1;
        unique case (state_q)
            StStop: begin
                if (clr_ev) begin
                    cnt_d = '0;
                end else if (ss_ev) begin
                    state_d = StRun;
                end
            end
            StRun, StLap: begin
                if (tick && !at_max) begin
                    cnt_d = incr(cnt_q);
                end
                if (ss_ev) begin
                    state_d = StStop;
                end else if (lap_ev) begin
                    if (state_q == StRun) begin
                        state_d = StLap;
                        latch_d = cnt_q;
                    end else begin
                        state_d = StRun;
                    end
                end else if (tick && at_max) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                blink_d = tick ? ~blink_q : blink_q;
                if (clr_ev) begin
                    state_d = StStop;
                    cnt_d   = '0;
                    blink_d = 1'b1;
                end
            end
            default: state_d = StStop;
        endcase
        // Prescaler parks at 0 while stopped so a start always gets a full period.
        if (state_q == StStop || state_d == StStop || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StStop;
            cnt_q        <= '0;
            latch_q      <= '0;
            presc_q      <= '0;
            blink_q      <= 1'b1;
            ss_q         <= 1'b1;
            clr_q        <= 1'b1;
            lap_btn_q    <= 1'b1;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            presc_q      <= presc_d;
            blink_q      <= blink_d;
            ss_q         <= START_STOP;
            clr_q        <= CLEAR;
            lap_btn_q    <= LAP;
            running_q    <= (state_d == StRun) || (state_d == StLap);
            lap_active_q <= (state_d == StLap);
            done_q       <= (state_d == StDone);
        end
    end

    always_comb begin
        if (state_q == StLap) begin
            {MIN_1, MIN_0, SEC_1, SEC_0} = latch_q;
        end else begin
            {MIN_1, MIN_0, SEC_1, SEC_0} = cnt_q;
        end
    end

    assign RUNNING    = running_q;
    assign LAP_ACTIVE = lap_active_q;
    assign DONE       = done_q;
    assign BLINK      = blink_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Bench for stopwatch_mmss: vector table, hand-written corner sequences and random stimulus,
// all checked against a seconds-based reference model.
module tb_stopwatch_mmss;

    localparam int unsigned CLK_HZ = 4;

    logic       MCLK, RST_N, START_STOP, CLEAR, LAP;
    logic [2:0] MIN_1, SEC_1;
    logic [3:0] MIN_0, SEC_0;
    logic       RUNNING, LAP_ACTIVE, DONE, BLINK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0=stop 1=run 2=lap 3=done; count kept as total seconds.
    int m_mode, m_secs, m_lap, m_phase;
    bit m_blink, m_pss, m_pclr, m_plap;

    stopwatch_mmss #(.CLK_HZ(CLK_HZ)) dut (
        .MCLK      (MCLK),
        .RST_N     (RST_N),
        .START_STOP(START_STOP),
        .CLEAR     (CLEAR),
        .LAP       (LAP),
        .MIN_1     (MIN_1),
        .MIN_0     (MIN_0),
        .SEC_1     (SEC_1),
        .SEC_0     (SEC_0),
        .RUNNING   (RUNNING),
        .LAP_ACTIVE(LAP_ACTIVE),
        .DONE      (DONE),
        .BLINK     (BLINK)
    );

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    typedef struct {
        logic  ss;
        logic  clr;
        logic  lp;
        int    n;
        int    secs;
        logic  run;
        logic  la;
        logic  dn;
        logic  bl;
        string name;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [17:0] pack(int s, logic run, logic la, logic dn, logic bl);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), run, la, dn, bl};
    endfunction

    function automatic logic [17:0] got_vec();
        return {MIN_1, MIN_0, SEC_1, SEC_0, RUNNING, LAP_ACTIVE, DONE, BLINK};
    endfunction

    task automatic m_reset();
        m_mode  = 0;
        m_secs  = 0;
        m_lap   = 0;
        m_phase = 0;
        m_blink = 1'b1;
        m_pss   = 1'b1;
        m_pclr  = 1'b1;
        m_plap  = 1'b1;
    endtask

    task automatic model_step(input logic ss, input logic clr, input logic lp);
        bit e_ss, e_clr, e_lap, tick;
        int nm, ns;
        e_ss  = m_pss && !ss;
        e_clr = m_pclr && !clr;
        e_lap = m_plap && !lp;
        tick  = (m_mode != 0) && (m_phase == CLK_HZ - 1);
        nm = m_mode;
        ns = m_secs;
        case (m_mode)
            0: begin
                if (e_clr) ns = 0;
                else if (e_ss) nm = 1;
            end
            1, 2: begin
                if (tick && m_secs < 3599) ns = m_secs + 1;
                if (e_ss) nm = 0;
                else if (e_lap) begin
                    if (m_mode == 1) begin
                        nm = 2;
                        m_lap = m_secs;
                    end else begin
                        nm = 1;
                    end
                end else if (tick && m_secs == 3599) nm = 3;
            end
            default: begin
                if (e_clr) begin
                    nm = 0;
                    ns = 0;
                end
            end
        endcase
        if (nm == 3 && m_mode == 3) m_blink = tick ? !m_blink : m_blink;
        else m_blink = 1'b1;
        m_phase = (m_mode == 0 || nm == 0) ? 0 : (m_phase + 1) % CLK_HZ;
        m_mode  = nm;
        m_secs  = ns;
        m_pss   = ss;
        m_pclr  = clr;
        m_plap  = lp;
    endtask

    task automatic compare(input string name, input logic [17:0] exp);
        logic [17:0] got;
        got = got_vec();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got mm:ss/flags %h required %h", name, $time, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        compare(name, pack(m_mode == 2 ? m_lap : m_secs, m_mode == 1 || m_mode == 2,
                           m_mode == 2, m_mode == 3, m_blink));
    endtask

    // One MCLK cycle: drive levels, let the edge happen, then check against the model.
    task automatic cycle(input logic ss, input logic clr, input logic lp);
        START_STOP = ss;
        CLEAR      = clr;
        LAP        = lp;
        @(posedge MCLK);
        model_step(ss, clr, lp);
        #1;
        check_model("model");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        logic rs, rc, rl;
        vecs[0] = '{1'b1, 1'b1, 1'b1, 20, 0, 1'b0, 1'b0, 1'b0, 1'b1, "idle"};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 41, 10, 1'b1, 1'b0, 1'b0, 1'b1, "run_to_10"};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1, 10, 1'b1, 1'b0, 1'b0, 1'b1, "release"};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1, 10, 1'b0, 1'b0, 1'b0, 1'b1, "stop_keep"};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, "clear_stop"};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_after_clear"};

        RST_N = 1'b0;
        START_STOP = 1'b1;
        CLEAR = 1'b1;
        LAP = 1'b1;
        m_reset();
        #12;
        RST_N = 1'b1;
        compare("reset", pack(0, 1'b0, 1'b0, 1'b0, 1'b1));

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].n; k++) cycle(vecs[v].ss, vecs[v].clr, vecs[v].lp);
            compare(vecs[v].name, pack(vecs[v].secs, vecs[v].run, vecs[v].la, vecs[v].dn,
                                       vecs[v].bl));
        end

        // Lap freeze at 00:59 while the live count moves on to 01:01.
        cycle(1'b0, 1'b1, 1'b1);
        idle(236);
        cycle(1'b1, 1'b1, 1'b0);
        idle(8);
        compare("lap_frozen", pack(59, 1'b1, 1'b1, 1'b0, 1'b1));
        cycle(1'b1, 1'b1, 1'b0);
        compare("lap_release", pack(61, 1'b1, 1'b0, 1'b0, 1'b1));
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        compare("clear_after_lap", pack(0, 1'b0, 1'b0, 1'b0, 1'b1));
        idle(1);

        // CLEAR and START_STOP together in RUN: stop wins, count kept.
        cycle(1'b0, 1'b1, 1'b1);
        idle(10);
        cycle(1'b0, 1'b0, 1'b1);
        compare("clr_ss_coincident", pack(2, 1'b0, 1'b0, 1'b0, 1'b1));
        idle(1);
        cycle(1'b1, 1'b0, 1'b1);
        compare("clear_in_stop", pack(0, 1'b0, 1'b0, 1'b0, 1'b1));
        idle(1);

        // Saturation at 59:59, blink, ignored buttons, clear out of DONE.
        cycle(1'b0, 1'b1, 1'b1);
        idle(14392);
        compare("at_59_58", pack(3598, 1'b1, 1'b0, 1'b0, 1'b1));
        idle(8);
        compare("done_entry", pack(3599, 1'b0, 1'b0, 1'b1, 1'b1));
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        idle(2);
        compare("done_blink_off", pack(3599, 1'b0, 1'b0, 1'b1, 1'b0));
        idle(4);
        compare("done_blink_on", pack(3599, 1'b0, 1'b0, 1'b1, 1'b1));
        cycle(1'b1, 1'b0, 1'b1);
        compare("done_clear", pack(0, 1'b0, 1'b0, 1'b0, 1'b1));
        idle(1);

        // Random button activity against the model.
        rs = 1'b1;
        rc = 1'b1;
        rl = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rs = ~rs;
            if ($urandom_range(0, 30) == 0) rc = ~rc;
            if ($urandom_range(0, 7) == 0) rl = ~rl;
            cycle(rs, rc, rl);
        end

        // Asynchronous reset in the middle of a running count.
        #2;
        RST_N = 1'b0;
        m_reset();
        START_STOP = 1'b1;
        CLEAR = 1'b1;
        LAP = 1'b1;
        #10;
        RST_N = 1'b1;
        idle(2);
        cycle(1'b0, 1'b1, 1'b1);
        idle(12);
        compare("pre_async_reset", pack(3, 1'b1, 1'b0, 1'b0, 1'b1));
        #2;
        RST_N = 1'b0;
        m_reset();
        #1;
        compare("async_reset", pack(0, 1'b0, 1'b0, 1'b0, 1'b1));
        #10;
        RST_N = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
